// File: rtl/mainreg_ctrl_pkg.sv
// Shared definitions for the main register file controller: operation
// encodings, register indices, FSM state encoding and a small helper.
package mainreg_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int REG_W  = 2;

    typedef logic [1:0]        op_t;
    typedef logic [REG_W-1:0]  reg_idx_t;
    typedef logic [DATA_W-1:0] data_t;

    localparam op_t OP_READ  = 2'b00;
    localparam op_t OP_WRITE = 2'b01;
    localparam op_t OP_MOVE  = 2'b10;
    localparam op_t OP_SWAP  = 2'b11;

    localparam reg_idx_t REG_A  = 2'd0;
    localparam reg_idx_t REG_B  = 2'd1;
    localparam reg_idx_t REG_C  = 2'd2;
    localparam reg_idx_t REG_IX = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_SW   = 2'd3;

    // True when the given state is the last working state of a command, so
    // the completion pulse should follow in the next cycle. A MOVE continues
    // from RD into WR, so RD is only final for a plain READ.
    function automatic logic is_final(input logic [1:0] st, input op_t op);
        return ((st == ST_RD) && (op != OP_MOVE)) || (st == ST_WR) || (st == ST_SW);
    endfunction

endpackage

// File: rtl/mainreg_ctrl_if.sv
// Requester-side bundle of the controller: two command ports with their
// ready handshakes, plus the shared completion report.
interface mainreg_ctrl_if;

    logic                      req0_valid;
    mainreg_ctrl_pkg::op_t     req0_op;
    mainreg_ctrl_pkg::reg_idx_t req0_dst;
    mainreg_ctrl_pkg::reg_idx_t req0_src;
    mainreg_ctrl_pkg::data_t   req0_data;
    logic                      req0_ready;

    logic                      req1_valid;
    mainreg_ctrl_pkg::op_t     req1_op;
    mainreg_ctrl_pkg::reg_idx_t req1_dst;
    mainreg_ctrl_pkg::reg_idx_t req1_src;
    mainreg_ctrl_pkg::data_t   req1_data;
    logic                      req1_ready;

    logic                      done;
    logic                      done_id;
    mainreg_ctrl_pkg::data_t   rdata;

    modport master (
        output req0_valid, req0_op, req0_dst, req0_src, req0_data,
        output req1_valid, req1_op, req1_dst, req1_src, req1_data,
        input  req0_ready, req1_ready, done, done_id, rdata
    );

    modport slave (
        input  req0_valid, req0_op, req0_dst, req0_src, req0_data,
        input  req1_valid, req1_op, req1_dst, req1_src, req1_data,
        output req0_ready, req1_ready, done, done_id, rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. A lone request is granted directly; when both
// request, the side that did not win last time gets the grant. The memory of
// the last winner resets to requester 1 so requester 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant, suppressed entirely while the controller cannot accept
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    // Remember which requester won every time a grant is actually taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (|grant) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mainreg_ctrl.sv
// Controller that serialises READ/WRITE/MOVE/SWAP commands from two
// requesters onto the control pins of the external main register file.
// Every read passes through the hold register, which also feeds the
// register-file write data and the read result.
module mainreg_ctrl
    import mainreg_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    mainreg_ctrl_if.slave  bus,
    output logic           mrwe,
    output logic           wa0,
    output logic           wa1,
    output logic           ra0,
    output logic           ra1,
    output logic           ra2,
    output logic           ra3,
    output logic           ra4,
    output logic           swapr,
    output data_t          rf_in,
    input  data_t          rf_outa,
    output logic           busy
);

    logic [1:0] state;
    logic [1:0] next_state;
    op_t        cmd_op;
    reg_idx_t   cmd_dst;
    reg_idx_t   cmd_src;
    logic       cmd_id;
    data_t      hold;
    logic       done_q;

    logic       idle;
    logic [1:0] grant;
    logic       accept;
    logic       acc_id;
    op_t        sel_op;
    reg_idx_t   sel_dst;
    reg_idx_t   sel_src;
    data_t      sel_data;
    reg_idx_t   wa;
    reg_idx_t   ra_lo;
    reg_idx_t   ra_hi;

    assign idle = (state == ST_IDLE);

    // Reset is folded into the enable so no READY can show while held in reset
    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (idle & rst_n),
        .req   ({bus.req1_valid, bus.req0_valid}),
        .grant (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign accept         = |grant;
    assign acc_id         = grant[1];

    // Pick the command fields of whichever requester was granted
    always_comb begin
        sel_op   = bus.req0_op;
        sel_dst  = bus.req0_dst;
        sel_src  = bus.req0_src;
        sel_data = bus.req0_data;
        if (acc_id) begin
            sel_op   = bus.req1_op;
            sel_dst  = bus.req1_dst;
            sel_src  = bus.req1_src;
            sel_data = bus.req1_data;
        end
    end

    // Next-state decode: IDLE dispatches on the accepted op, RD chains into WR for MOVE
    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (sel_op)
                        OP_READ:  next_state = ST_RD;
                        OP_WRITE: next_state = ST_WR;
                        OP_MOVE:  next_state = ST_RD;
                        default:  next_state = ST_SW;
                    endcase
                end
            end
            ST_RD:   next_state = (cmd_op == OP_MOVE) ? ST_WR : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // State register plus the latched command, captured only on an accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cmd_op  <= OP_READ;
            cmd_dst <= REG_A;
            cmd_src <= REG_A;
            cmd_id  <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                cmd_op  <= sel_op;
                cmd_dst <= sel_dst;
                cmd_src <= sel_src;
                cmd_id  <= acc_id;
            end
        end
    end

    // Hold register: loaded with WRITE data on accept, or with port-A data at the end of RD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (accept && (sel_op == OP_WRITE)) begin
            hold <= sel_data;
        end else if (state == ST_RD) begin
            hold <= rf_outa;
        end
    end

    // Completion pulse lands in the cycle after the last working state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= is_final(state, cmd_op);
        end
    end

    // Register-file controls per working state; everything stays low in IDLE
    always_comb begin
        mrwe  = 1'b0;
        swapr = 1'b0;
        wa    = '0;
        ra_lo = '0;
        ra_hi = '0;
        case (state)
            ST_RD: begin
                ra_lo = cmd_src;
            end
            ST_WR: begin
                mrwe = 1'b1;
                wa   = cmd_dst;
            end
            ST_SW: begin
                swapr = 1'b1;
                ra_lo = cmd_dst;
                ra_hi = cmd_src;
            end
            default: begin
                mrwe = 1'b0;
            end
        endcase
    end

    assign wa0         = wa[0];
    assign wa1         = wa[1];
    assign ra0         = ra_lo[0];
    assign ra1         = ra_lo[1];
    assign ra2         = ra_hi[0];
    assign ra3         = ra_hi[1];
    assign ra4         = 1'b0;
    assign rf_in       = hold;
    assign busy        = !idle;
    assign bus.done    = done_q;
    assign bus.done_id = cmd_id;
    assign bus.rdata   = hold;

endmodule

// File: tb/tb_mainreg_ctrl.sv
// Testbench for mainreg_ctrl. A behavioural stand-in for the main register
// file is driven by the controller pins; a high-level reference model of the
// four registers predicts each completion, which a monitor compares.
module tb_mainreg_ctrl;
    import mainreg_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mainreg_ctrl_if bus();

    logic  mrwe, wa0, wa1, ra0, ra1, ra2, ra3, ra4, swapr, busy;
    data_t rf_in;
    data_t rf_outa;

    mainreg_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .mrwe    (mrwe),
        .wa0     (wa0),
        .wa1     (wa1),
        .ra0     (ra0),
        .ra1     (ra1),
        .ra2     (ra2),
        .ra3     (ra3),
        .ra4     (ra4),
        .swapr   (swapr),
        .rf_in   (rf_in),
        .rf_outa (rf_outa),
        .busy    (busy)
    );

    // Stand-in for the main register file: port-A read, write port, swap, shared reset
    logic [7:0] rf [4];
    assign rf_outa = rf[{ra1, ra0}];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
        end else begin
            if (mrwe) rf[{wa1, wa0}] <= rf_in;
            if (swapr) begin
                rf[{ra1, ra0}] <= rf[{ra3, ra2}];
                rf[{ra3, ra2}] <= rf[{ra1, ra0}];
            end
        end
    end

    typedef struct packed {
        logic [1:0] op;
        logic [1:0] dst;
        logic [1:0] src;
        logic [7:0] data;
    } cmd_t;

    typedef struct {
        int         id;
        logic [7:0] rdata;
        int         due;
    } exp_t;

    cmd_t q0[$];
    cmd_t q1[$];
    exp_t expq[$];
    logic [7:0] ref_regs [4];
    logic [7:0] ref_hold;
    logic       ref_last;
    logic       acc0 = 1'b0;
    logic       acc1 = 1'b0;
    cmd_t       cur0;
    cmd_t       cur1;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    // Cycle counter used to time completions
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [1:0] op, input logic [1:0] dst,
                                 input logic [1:0] src, input logic [7:0] data);
        cmd_t c;
        c.op = op; c.dst = dst; c.src = src; c.data = data;
        if (id == 0) q0.push_back(c);
        else q1.push_back(c);
    endtask

    // Reference model: apply a command's effect to the registers and predict its completion
    task automatic modelAccept(input int id, input cmd_t c);
        exp_t e;
        logic [7:0] tmp;
        int lat;
        lat = 2;
        case (c.op)
            OP_READ:  ref_hold = ref_regs[c.src];
            OP_WRITE: begin ref_hold = c.data; ref_regs[c.dst] = c.data; end
            OP_MOVE:  begin ref_hold = ref_regs[c.src]; ref_regs[c.dst] = ref_hold; lat = 3; end
            default: begin
                tmp = ref_regs[c.dst];
                ref_regs[c.dst] = ref_regs[c.src];
                ref_regs[c.src] = tmp;
            end
        endcase
        e.id = id;
        e.rdata = ref_hold;
        // the accepting cycle is the one that ended at the edge just counted
        e.due = (cyc - 1) + lat;
        ref_last = (id == 1);
        expq.push_back(e);
    endtask

    // Requester driver: retire accepted commands, present the next, then check the handshake
    always @(negedge clk) begin
        logic [1:0] expg;
        if (!rst_n) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
            acc0 = 1'b0;
            acc1 = 1'b0;
        end else begin
            if (acc0) begin modelAccept(0, cur0); bus.req0_valid = 1'b0; end
            if (acc1) begin modelAccept(1, cur1); bus.req1_valid = 1'b0; end
            if (!bus.req0_valid && q0.size() > 0) begin
                cur0 = q0.pop_front();
                bus.req0_op = cur0.op; bus.req0_dst = cur0.dst;
                bus.req0_src = cur0.src; bus.req0_data = cur0.data;
                bus.req0_valid = 1'b1;
            end
            if (!bus.req1_valid && q1.size() > 0) begin
                cur1 = q1.pop_front();
                bus.req1_op = cur1.op; bus.req1_dst = cur1.dst;
                bus.req1_src = cur1.src; bus.req1_data = cur1.data;
                bus.req1_valid = 1'b1;
            end
            #2;
            acc0 = bus.req0_valid & bus.req0_ready;
            acc1 = bus.req1_valid & bus.req1_ready;
            checkOutput("ready_exclusive", {31'd0, bus.req0_ready & bus.req1_ready}, 32'd0);
            if (busy) begin
                checkOutput("ready_while_busy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            end else if (bus.req0_valid || bus.req1_valid) begin
                if (bus.req0_valid && bus.req1_valid) expg = ref_last ? 2'b01 : 2'b10;
                else expg = {bus.req1_valid, bus.req0_valid};
                checkOutput("grant", {30'd0, bus.req1_ready, bus.req0_ready}, {30'd0, expg});
            end
        end
    end

    // Completion monitor: every DONE pulse must match the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                checkOutput("done_id", {31'd0, bus.done_id}, e.id);
                checkOutput("rdata", {24'd0, bus.rdata}, {24'd0, e.rdata});
                checkOutput("done_cycle", cyc, e.due);
            end
        end
    end

    // Pin-level rules that hold in every cycle
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("ra4", {31'd0, ra4}, 32'd0);
            if (!busy) checkOutput("idle_ctrl", {23'd0, mrwe, wa1, wa0, ra3, ra2, ra1, ra0, swapr, bus.done & 1'b0}, 32'd0);
        end
    end

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #4;
            n++;
        end while ((q0.size() > 0 || q1.size() > 0 || bus.req0_valid || bus.req1_valid ||
                    expq.size() > 0 || busy) && n < budget);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("[TB] FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic compareRegs();
        for (int i = 0; i < 4; i++) checkOutput($sformatf("reg%0d", i), {24'd0, rf[i]}, {24'd0, ref_regs[i]});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"}, {23'd0, mrwe, wa1, wa0, ra4, ra3, ra2, ra1, ra0, swapr}, 32'd0);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        checkOutput({tag, "_done_id"}, {31'd0, bus.done_id}, 32'd0);
        checkOutput({tag, "_rf_in"}, {24'd0, rf_in}, 32'd0);
        checkOutput({tag, "_rdata"}, {24'd0, bus.rdata}, 32'd0);
        checkOutput({tag, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_hold = 8'h00;
        ref_last = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] directed WRITE / MOVE / SWAP / READ");
        applyStimulus(0, OP_WRITE, REG_B, REG_A, 8'h5A);
        waitIdle(50);
        compareRegs();
        applyStimulus(0, OP_MOVE, REG_C, REG_B, 8'h00);
        waitIdle(50);
        compareRegs();
        applyStimulus(0, OP_WRITE, REG_A, REG_A, 8'h11);
        applyStimulus(0, OP_WRITE, REG_IX, REG_A, 8'h22);
        applyStimulus(1, OP_READ, REG_A, REG_IX, 8'h00);
        waitIdle(50);
        applyStimulus(0, OP_SWAP, REG_A, REG_IX, 8'h00);
        applyStimulus(0, OP_READ, REG_A, REG_A, 8'h00);
        applyStimulus(0, OP_READ, REG_A, REG_IX, 8'h00);
        waitIdle(50);
        compareRegs();
        applyStimulus(1, OP_MOVE, REG_A, REG_A, 8'h00);
        applyStimulus(1, OP_SWAP, REG_B, REG_B, 8'h00);
        waitIdle(50);
        compareRegs();

        $display("[TB] reset during the WR cycle of a MOVE");
        applyStimulus(0, OP_MOVE, REG_A, REG_C, 8'h00);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!mrwe && n < 20);
        checkOutput("move_reaches_wr", {31'd0, mrwe}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        expq.delete();
        for (int i = 0; i < 4; i++) ref_regs[i] = 8'h00;
        ref_hold = 8'h00;
        ref_last = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] both requesters contending");
        applyStimulus(0, OP_WRITE, REG_A, REG_A, 8'h33);
        applyStimulus(0, OP_READ, REG_A, REG_A, 8'h00);
        applyStimulus(1, OP_WRITE, REG_B, REG_A, 8'h44);
        applyStimulus(1, OP_READ, REG_A, REG_B, 8'h00);
        waitIdle(50);
        compareRegs();

        $display("[TB] random command mix");
        for (int k = 0; k < 80; k++) begin
            applyStimulus($urandom_range(0, 1), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        waitIdle(2000);
        compareRegs();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mainreg_ctrl.md
MAINREG_CTRL -- requirements
Module: mainreg_ctrl

Interface
REQ-001 SHALL have no parameters; data width fixed at 8, register index width fixed at 2.
REQ-002 SHALL use one clock and an asynchronous active-low reset: CLK  in  1  rising-edge clock.
REQ-003 RESET  in  1  asynchronous active-low reset, shared with the main register file.
REQ-004 REQ0_VALID / REQ1_VALID  in  1 each  requester command valid.
REQ-005 REQn_OP  in  2  00 READ, 01 WRITE, 10 MOVE, 11 SWAP.
REQ-006 REQn_DST, REQn_SRC  in  2 each  register index: 0 A, 1 B, 2 C, 3 IX.
REQ-007 REQn_DATA  in  8  write data for WRITE.
REQ-008 REQ0_READY / REQ1_READY  out  1 each  command accepted this cycle.
REQ-009 DONE  out  1  one-cycle completion pulse; DONE_ID  out  1  requester that completed; RDATA  out  8  READ result, valid with DONE.
REQ-010 MRWE, WA0, WA1, RA0, RA1, RA2, RA3, RA4, SWAPR  out  1 each  register file controls.
REQ-011 RF_IN  out  8  register file write data; RF_OUTA  in  8  register file port-A read data.
REQ-012 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, RD, WR, SW.
REQ-014 READY SHALL be asserted only in IDLE, to at most one requester, combinationally from VALIDs and the arbiter.
REQ-015 Arbitration: only one VALID -> grant it; both VALID -> grant the requester not granted last; LAST_GRANT register updates on each accept.
REQ-016 On accept (READY & VALID at edge), SHALL latch op, dst, src, grant id; for WRITE, SHALL load DATA into the hold register.
REQ-017 Transitions from IDLE: READ -> RD; WRITE -> WR; MOVE -> RD; SWAP -> SW.
REQ-018 RD: RA1:RA0 = src; RF_OUTA captured into the hold register at cycle end; next WR if MOVE, else IDLE.
REQ-019 WR: MRWE=1, WA1:WA0 = dst, RF_IN = hold register; next IDLE.
REQ-020 SW: SWAPR=1, RA1:RA0 = dst, RA3:RA2 = src, MRWE=0; next IDLE.
REQ-021 In IDLE, all register-file control outputs SHALL be 0; RA4 SHALL always be 0; RF_IN SHALL equal the hold register at all times.
REQ-022 DONE SHALL be a registered pulse in the cycle after the final op state, with DONE_ID = latched grant id and RDATA = hold register.
REQ-023 Latency from accept edge to DONE: READ, WRITE, SWAP 2 cycles; MOVE 3 cycles.
REQ-024 A new command MAY be accepted in the same cycle DONE is high, giving a throughput of one command per 2 cycles (3 for MOVE).
REQ-025 MOVE/SWAP with dst == src SHALL execute the full sequence unchanged.
REQ-026 A VALID that is not granted SHALL wait; the requester holds its command stable until READY.

Reset
REQ-027 RESET low SHALL asynchronously force state IDLE, hold register 0x00, LAST_GRANT = 1 (REQ0 first priority), DONE 0, and all outputs 0.
REQ-028 Reset mid-operation SHALL abandon the command with no DONE pulse; the first command after release is accepted in the first IDLE cycle.

Structure
REQ-029 Shared package mainreg_ctrl_pkg SHALL hold the op encodings, the register index constants, and the state encoding.
REQ-030 Arbitration SHALL be a sub-module rr_arb2 (two requests, LAST_GRANT register, one-hot grant).
REQ-031 RTL SHALL instantiate neither the register file nor a copy of it; the bench connects mainreg_ctrl to the existing mainreg.

Verification
REQ-032 WRITE B=0x5A from REQ0 -> WR cycle with MRWE=1 and WA=01; DONE 2 cycles after accept with DONE_ID=0; register B reads 0x5A.
REQ-033 MOVE C<-B with B=0x5A -> RD (RA=01), then WR (WA=10, RF_IN=0x5A); DONE at +3; C reads 0x5A.
REQ-034 SWAP A(0x11),IX(0x22) -> one SWAPR cycle with RA1:0=00 and RA3:2=11; afterwards A=0x22 and IX=0x11; DONE at +2.
REQ-035 Both VALID held for 4 commands -> grants alternate 0,1,0,1 after reset; READY is never high for both in one cycle.
REQ-036 READ IX=0x22 -> RDATA=0x22 with DONE; assert RESET during the WR cycle of a MOVE -> no DONE, all outputs 0, BUSY 0, next command accepted normally.
